// File: rtl/cc_command_gen.sv
// cc_command_gen: cleans raw stalk buttons and pedals into ccc command pulses and levels.
// Build option: define CC_AUTOREPEAT_EN to include auto-repeat of held accel/coast.
module cc_command_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 4,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_set,
    input  logic       btn_resume,
    input  logic       btn_cancel,
    input  logic       btn_accel,
    input  logic       btn_coast,
    input  logic       pedal_brake,
    input  logic       pedal_throttle,
    input  logic       cruisecontrol,
    output logic       set,
    output logic       resume,
    output logic       cancel,
    output logic       accel,
    output logic       coast,
    output logic       brake,
    output logic       throttle,
    output logic       fault,
    output logic [3:0] dbg_rpt_state
);

    localparam int NB  = 6;
    localparam int CAN = 0;
    localparam int SET = 1;
    localparam int RES = 2;
    localparam int ACC = 3;
    localparam int CST = 4;
    localparam int THR = 5;
    localparam int BRK = 6;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [6:0]       raw;
    logic [6:0]       sync1;
    logic [6:0]       sync2;
    logic [NB-1:0]    deb;
    logic [CNT_W-1:0] db_cnt [NB];
    logic [4:0]       deb_q;
    logic [4:0]       rise;
    logic             fault_now;
    logic [1:0]       rpt_req;
    logic [4:0]       cmd_n;
    logic             req_can;
    logic             req_set;
    logic             req_res;
    logic             req_acc;
    logic             req_cst;

    assign raw = {pedal_brake, pedal_throttle, btn_coast, btn_accel,
                  btn_resume, btn_set, btn_cancel};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Brake bypasses debounce so the pedal acts with minimum latency.
    assign brake = sync2[BRK];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb <= '0;
            for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] >= DB_LAST) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) deb_q <= '0;
        else        deb_q <= deb[4:0];
    end

    assign rise      = deb[4:0] & ~deb_q;
    assign throttle  = deb[THR];
    assign fault_now = deb[ACC] & deb[CST];
    assign fault     = fault_now;

`ifdef CC_AUTOREPEAT_EN
    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    rpt_state_t       rpt_state   [2];
    rpt_state_t       rpt_state_n [2];
    logic [CNT_W-1:0] rpt_cnt     [2];
    logic [CNT_W-1:0] rpt_cnt_n   [2];
    logic [1:0]       rpt_rise;
    logic [1:0]       rpt_keep;

    // Index 0 is accel, index 1 is coast.
    assign rpt_rise = rise[CST:ACC];
    assign rpt_keep = deb[CST:ACC] & {2{cruisecontrol & ~brake & ~fault_now}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                rpt_state[i] <= RPT_IDLE;
                rpt_cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                rpt_state[i] <= rpt_state_n[i];
                rpt_cnt[i]   <= rpt_cnt_n[i];
            end
        end
    end

    always_comb begin
        rpt_req = '0;
        for (int i = 0; i < 2; i++) begin
            rpt_state_n[i] = rpt_state[i];
            rpt_cnt_n[i]   = rpt_cnt[i];
            if (!rpt_keep[i]) begin
                rpt_state_n[i] = RPT_IDLE;
                rpt_cnt_n[i]   = '0;
            end else begin
                case (rpt_state[i])
                    RPT_IDLE: begin
                        if (rpt_rise[i]) begin
                            rpt_state_n[i] = RPT_DELAY;
                            rpt_cnt_n[i]   = '0;
                        end
                    end
                    RPT_DELAY: begin
                        if (rpt_cnt[i] >= RD_LAST) begin
                            rpt_req[i]     = 1'b1;
                            rpt_state_n[i] = RPT_REPEAT;
                            rpt_cnt_n[i]   = '0;
                        end else if (rpt_cnt[i] != '1) begin
                            rpt_cnt_n[i] = rpt_cnt[i] + 1'b1;
                        end
                    end
                    RPT_REPEAT: begin
                        if (rpt_cnt[i] >= RP_LAST) begin
                            rpt_req[i]   = 1'b1;
                            rpt_cnt_n[i] = '0;
                        end else if (rpt_cnt[i] != '1) begin
                            rpt_cnt_n[i] = rpt_cnt[i] + 1'b1;
                        end
                    end
                    default: begin
                        rpt_state_n[i] = RPT_IDLE;
                        rpt_cnt_n[i]   = '0;
                    end
                endcase
            end
        end
    end

    assign dbg_rpt_state = {rpt_state[1], rpt_state[0]};
`else
    logic unused_rpt_cfg;

    assign rpt_req        = 2'b00;
    assign dbg_rpt_state  = 4'h0;
    assign unused_rpt_cfg = cruisecontrol ^ (REPEAT_DELAY == REPEAT_PERIOD);
`endif

    always_comb begin
        req_can = rise[CAN];
        req_set = rise[SET] & ~brake;
        req_res = rise[RES] & ~brake;
        req_acc = (rise[ACC] | rpt_req[0]) & ~brake & ~fault_now;
        req_cst = (rise[CST] | rpt_req[1]) & ~brake & ~fault_now;
        cmd_n   = '0;
        // Losing requests are dropped, never held over to a later cycle.
        if (req_can)      cmd_n[CAN] = 1'b1;
        else if (req_set) cmd_n[SET] = 1'b1;
        else if (req_res) cmd_n[RES] = 1'b1;
        else if (req_acc) cmd_n[ACC] = 1'b1;
        else if (req_cst) cmd_n[CST] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cancel <= 1'b0;
            set    <= 1'b0;
            resume <= 1'b0;
            accel  <= 1'b0;
            coast  <= 1'b0;
        end else begin
            cancel <= cmd_n[CAN];
            set    <= cmd_n[SET];
            resume <= cmd_n[RES];
            accel  <= cmd_n[ACC];
            coast  <= cmd_n[CST];
        end
    end

endmodule

// File: tb/tb_cc_command_gen.sv
// tb_cc_command_gen: randomized and directed checks of cc_command_gen against a
// cycle-indexed behavioural model of debounce, arbitration, gating and auto-repeat.
module tb_cc_command_gen;

    localparam int DB   = 4;
    localparam int NCYC = 120;
`ifdef CC_AUTOREPEAT_EN
    localparam int RD = 8;
    localparam int RP = 4;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_set, btn_resume, btn_cancel, btn_accel, btn_coast;
    logic       pedal_brake, pedal_throttle, cruisecontrol;
    logic       set, resume, cancel, accel, coast, brake, throttle, fault;
    logic [3:0] dbg_rpt_state;

    cc_command_gen dut (
        .clk(clk), .reset(reset),
        .btn_set(btn_set), .btn_resume(btn_resume), .btn_cancel(btn_cancel),
        .btn_accel(btn_accel), .btn_coast(btn_coast),
        .pedal_brake(pedal_brake), .pedal_throttle(pedal_throttle),
        .cruisecontrol(cruisecontrol),
        .set(set), .resume(resume), .cancel(cancel), .accel(accel), .coast(coast),
        .brake(brake), .throttle(throttle), .fault(fault),
        .dbg_rpt_state(dbg_rpt_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [127:0] p_set, p_resume, p_cancel, p_accel, p_coast, p_brake, p_thr, p_cc;
    logic [127:0] obs_set, obs_resume, obs_cancel, obs_accel, obs_coast;
    logic [127:0] obs_brake, obs_thr, obs_fault;
    logic [127:0] exp_set, exp_resume, exp_cancel, exp_accel, exp_coast;
    logic [127:0] exp_brake, exp_thr, exp_fault;
    logic [7:0]   exp_q[$];

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        btn_set = 0; btn_resume = 0; btn_cancel = 0; btn_accel = 0; btn_coast = 0;
        pedal_brake = 0; pedal_throttle = 0; cruisecontrol = 0;
    endtask

    task automatic clear_patterns();
        p_set = '0; p_resume = '0; p_cancel = '0; p_accel = '0;
        p_coast = '0; p_brake = '0; p_thr = '0; p_cc = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Observation i is taken before stimulus i is driven; stimulus i is sampled at the next edge.
    task automatic run_pattern();
        obs_set = '0; obs_resume = '0; obs_cancel = '0; obs_accel = '0; obs_coast = '0;
        obs_brake = '0; obs_thr = '0; obs_fault = '0;
        for (int i = 0; i < NCYC; i++) begin
            @(negedge clk);
            obs_set[i] = set; obs_resume[i] = resume; obs_cancel[i] = cancel;
            obs_accel[i] = accel; obs_coast[i] = coast; obs_brake[i] = brake;
            obs_thr[i] = throttle; obs_fault[i] = fault;
            btn_set = p_set[i]; btn_resume = p_resume[i]; btn_cancel = p_cancel[i];
            btn_accel = p_accel[i]; btn_coast = p_coast[i]; pedal_brake = p_brake[i];
            pedal_throttle = p_thr[i]; cruisecontrol = p_cc[i];
        end
        clear_inputs();
    endtask

    task automatic gen_runs(input int max_run, output logic [127:0] v);
        logic lvl;
        int   j;
        int   len;
        v = '0; lvl = 1'b0; j = 0;
        while (j < 96) begin
            len = $urandom_range(max_run, 1);
            for (int k = 0; k < len && j < 96; k++) begin
                v[j] = lvl;
                j++;
            end
            lvl = ~lvl;
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic bit_at(input logic [127:0] v, input int i);
        return (i >= 0 && i < 128) ? v[i] : 1'b0;
    endfunction

    // Debounced level per sample index: flips once DB consecutive samples disagree with it.
    task automatic deb_model(input logic [127:0] s, output logic [127:0] l);
        logic lvl;
        int   run;
        lvl = 1'b0; run = 0; l = '0;
        for (int j = 0; j < 128; j++) begin
            if (s[j] !== lvl) run++;
            else run = 0;
            if (run == DB) begin
                lvl = s[j];
                run = 0;
            end
            l[j] = lvl;
        end
    endtask

`ifdef CC_AUTOREPEAT_EN
    // A train started at cycle s repeats at s+RD, s+RD+RP, ... while its hold condition persists.
    task automatic rpt_step(input int a, input logic rise, input logic keep,
                            inout int s, output logic rep);
        int d;
        rep = 1'b0;
        if (s >= 0) begin
            if (!keep) s = -1;
            else begin
                d = a - s;
                if (d == RD || (d > RD && (d - RD) % RP == 0)) rep = 1'b1;
            end
        end
        if (s < 0 && rise && keep) s = a;
    endtask
`endif

    task automatic build_expected();
        logic [127:0] l_can, l_set, l_res, l_acc, l_cst, l_thr;
        logic la, lc, b, f, cc;
        logic r_can, r_set, r_res, r_acc, r_cst, rep_a, rep_c;
        logic q_set, q_res, q_acc, q_cst;
        int   acc_s, cst_s;
        deb_model(p_cancel, l_can); deb_model(p_set, l_set); deb_model(p_resume, l_res);
        deb_model(p_accel, l_acc); deb_model(p_coast, l_cst); deb_model(p_thr, l_thr);
        exp_set = '0; exp_resume = '0; exp_cancel = '0; exp_accel = '0; exp_coast = '0;
        exp_brake = '0; exp_thr = '0; exp_fault = '0;
        acc_s = -1; cst_s = -1;
        for (int a = 0; a < NCYC; a++) begin
            la = bit_at(l_acc, a - 3);
            lc = bit_at(l_cst, a - 3);
            b  = bit_at(p_brake, a - 2);
            f  = la & lc;
            cc = p_cc[a];
            exp_brake[a] = b;
            exp_thr[a]   = bit_at(l_thr, a - 3);
            exp_fault[a] = f;
            r_can = bit_at(l_can, a - 3) & ~bit_at(l_can, a - 4);
            r_set = bit_at(l_set, a - 3) & ~bit_at(l_set, a - 4);
            r_res = bit_at(l_res, a - 3) & ~bit_at(l_res, a - 4);
            r_acc = la & ~bit_at(l_acc, a - 4);
            r_cst = lc & ~bit_at(l_cst, a - 4);
            rep_a = 1'b0; rep_c = 1'b0;
`ifdef CC_AUTOREPEAT_EN
            rpt_step(a, r_acc, la & cc & ~b & ~f, acc_s, rep_a);
            rpt_step(a, r_cst, lc & cc & ~b & ~f, cst_s, rep_c);
`endif
            q_set = r_set & ~b;
            q_res = r_res & ~b;
            q_acc = (r_acc | rep_a) & ~b & ~f;
            q_cst = (r_cst | rep_c) & ~b & ~f;
            if (a + 1 < NCYC) begin
                if (r_can)      exp_cancel[a+1] = 1'b1;
                else if (q_set) exp_set[a+1]    = 1'b1;
                else if (q_res) exp_resume[a+1] = 1'b1;
                else if (q_acc) exp_accel[a+1]  = 1'b1;
                else if (q_cst) exp_coast[a+1]  = 1'b1;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({set, resume, cancel, accel, coast, brake, throttle, fault, dbg_rpt_state} !== 12'h0) begin
                n_bad++;
                $display("FAIL reset.hold cyc=%0d got=%b exp=0", i,
                         {set, resume, cancel, accel, coast, brake, throttle, fault, dbg_rpt_state});
            end
            {btn_set, btn_resume, btn_cancel, btn_accel, btn_coast,
             pedal_brake, pedal_throttle, cruisecontrol} = 8'($urandom);
        end
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({set, resume, cancel, accel, coast, brake, throttle, fault} !== 8'h0) begin
                n_bad++;
                $display("FAIL reset.idle cyc=%0d got=%b exp=0", i,
                         {set, resume, cancel, accel, coast, brake, throttle, fault});
            end
        end
    endtask

    task automatic test_reset_abort();
        int need;
        int seen;
        int late;
`ifdef CC_AUTOREPEAT_EN
        need = 2;
`else
        need = 1;
`endif
        seen = 0; late = 0;
        do_reset();
        cruisecontrol = 1'b1;
        btn_accel = 1'b1;
        for (int i = 0; i < 40 && seen < need; i++) begin
            @(negedge clk);
            if (accel) seen++;
        end
        n_cmp++;
        if (seen != need) begin
            n_bad++;
            $display("FAIL abort.pulses_before_reset got=%0d exp=%0d", seen, need);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({set, resume, cancel, accel, coast, throttle, fault, dbg_rpt_state} !== 11'h0) begin
            n_bad++;
            $display("FAIL abort.async_clear got=%b exp=0",
                     {set, resume, cancel, accel, coast, throttle, fault, dbg_rpt_state});
        end
        btn_accel = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (accel || coast) late++;
        end
        n_cmp++;
        if (late != 0) begin
            n_bad++;
            $display("FAIL abort.after_release got=%0d exp=0", late);
        end
        clear_inputs();
    endtask

    task automatic test_debounce();
        // Press held 10 cycles from sample 2: one pulse, high after edge 2+6.
        do_reset(); clear_patterns();
        p_set[11:2] = '1;
        build_expected(); run_pattern();
        n_cmp++;
        if (obs_set !== (128'b1 << 9)) begin
            n_bad++; $display("FAIL debounce.set_press got=%h exp=%h", obs_set, 128'b1 << 9);
        end
        n_cmp++;
        if (obs_set !== exp_set) begin
            n_bad++; $display("FAIL debounce.set_model got=%h exp=%h", obs_set, exp_set);
        end
        // Short glitch below the debounce length.
        do_reset(); clear_patterns();
        p_resume[4:2] = '1;
        build_expected(); run_pattern();
        n_cmp++;
        if (obs_resume !== 128'b0 || obs_resume !== exp_resume) begin
            n_bad++; $display("FAIL debounce.glitch got=%h exp=%h", obs_resume, exp_resume);
        end
        // Chatter every cycle.
        do_reset(); clear_patterns();
        for (int i = 2; i < 22; i++) p_set[i] = i[0];
        build_expected(); run_pattern();
        n_cmp++;
        if (obs_set !== 128'b0 || obs_set !== exp_set) begin
            n_bad++; $display("FAIL debounce.chatter got=%h exp=%h", obs_set, exp_set);
        end
    endtask

    task automatic test_auto_repeat();
        logic [7:0] got_q[$];
        for (int pass = 0; pass < 2; pass++) begin
            do_reset(); clear_patterns();
            p_accel[31:2] = '1;
            p_cc = (pass == 0) ? '1 : '0;
            exp_q.delete();
            exp_q.push_back(8'd9);
`ifdef CC_AUTOREPEAT_EN
            if (pass == 0)
                for (int r = 8; r <= 28; r += 4) exp_q.push_back(8'(9 + r));
`endif
            build_expected(); run_pattern();
            got_q.delete();
            for (int i = 0; i < NCYC; i++) if (obs_accel[i]) got_q.push_back(8'(i));
            n_cmp++;
            if (got_q.size() != exp_q.size()) begin
                n_bad++;
                $display("FAIL repeat.count cc=%0d got=%0d exp=%0d", 1 - pass, got_q.size(), exp_q.size());
            end
            for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
                n_cmp++;
                if (got_q[k] !== exp_q[k]) begin
                    n_bad++;
                    $display("FAIL repeat.pos cc=%0d idx=%0d got=%0d exp=%0d", 1 - pass, k, got_q[k], exp_q[k]);
                end
            end
            n_cmp++;
            if (obs_accel !== exp_accel) begin
                n_bad++; $display("FAIL repeat.model got=%h exp=%h", obs_accel, exp_accel);
            end
        end
    endtask

    task automatic test_brake();
        do_reset(); clear_patterns();
        p_brake[60:0] = '1;
        p_set[15:3] = '1;
        p_cancel[40:30] = '1;
        build_expected(); run_pattern();
        n_cmp++;
        if (obs_brake[2:0] !== 3'b100) begin
            n_bad++; $display("FAIL brake.latency got=%b exp=100", obs_brake[2:0]);
        end
        n_cmp++;
        if (obs_set !== 128'b0) begin
            n_bad++; $display("FAIL brake.set_gated got=%h exp=0", obs_set);
        end
        n_cmp++;
        if (obs_cancel !== (128'b1 << 37)) begin
            n_bad++; $display("FAIL brake.cancel_passes got=%h exp=%h", obs_cancel, 128'b1 << 37);
        end
        n_cmp++;
        if (obs_brake !== exp_brake) begin
            n_bad++; $display("FAIL brake.model got=%h exp=%h", obs_brake, exp_brake);
        end
    endtask

    task automatic test_arbitration();
        do_reset(); clear_patterns();
        p_cancel[11:2] = '1;
        p_set[11:2] = '1;
        p_resume[51:42] = '1;
        p_accel[51:42] = '1;
        build_expected(); run_pattern();
        n_cmp++;
        if (obs_cancel !== (128'b1 << 9) || obs_set !== 128'b0) begin
            n_bad++; $display("FAIL arb.cancel_over_set got=%h/%h exp=%h/0", obs_cancel, obs_set, 128'b1 << 9);
        end
        n_cmp++;
        if (obs_resume !== (128'b1 << 49) || obs_accel !== 128'b0) begin
            n_bad++; $display("FAIL arb.resume_over_accel got=%h/%h exp=%h/0", obs_resume, obs_accel, 128'b1 << 49);
        end
    endtask

    task automatic test_fault();
        logic [127:0] want;
        do_reset(); clear_patterns();
        p_cc = '1;
        p_accel[60:2] = '1;
        p_coast[21:2] = '1;
        p_accel[85:70] = '1;
        build_expected(); run_pattern();
        want = '0;
        want[27:8] = '1;
        n_cmp++;
        if (obs_fault !== want) begin
            n_bad++; $display("FAIL fault.level got=%h exp=%h", obs_fault, want);
        end
        n_cmp++;
        if (obs_accel[76:0] !== 77'b0 || obs_accel[77] !== 1'b1 || obs_coast !== 128'b0) begin
            n_bad++; $display("FAIL fault.no_pulses got=%h/%h exp=first accel at 77", obs_accel, obs_coast);
        end
        n_cmp++;
        if (obs_accel !== exp_accel) begin
            n_bad++; $display("FAIL fault.model got=%h exp=%h", obs_accel, exp_accel);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            do_reset(); clear_patterns();
            gen_runs(8, p_set); gen_runs(8, p_resume); gen_runs(9, p_cancel);
            gen_runs(10, p_accel); gen_runs(10, p_coast); gen_runs(7, p_thr);
            gen_runs(24, p_brake); gen_runs(30, p_cc);
            build_expected(); run_pattern();
            n_cmp++;
            if ({obs_set, obs_resume, obs_cancel} !== {exp_set, exp_resume, exp_cancel}) begin
                n_bad++;
                $display("FAIL random%0d.set_resume_cancel got=%h %h %h exp=%h %h %h", r,
                         obs_set, obs_resume, obs_cancel, exp_set, exp_resume, exp_cancel);
            end
            n_cmp++;
            if ({obs_accel, obs_coast} !== {exp_accel, exp_coast}) begin
                n_bad++;
                $display("FAIL random%0d.accel_coast got=%h %h exp=%h %h", r,
                         obs_accel, obs_coast, exp_accel, exp_coast);
            end
            n_cmp++;
            if ({obs_brake, obs_thr, obs_fault} !== {exp_brake, exp_thr, exp_fault}) begin
                n_bad++;
                $display("FAIL random%0d.levels got=%h %h %h exp=%h %h %h", r,
                         obs_brake, obs_thr, obs_fault, exp_brake, exp_thr, exp_fault);
            end
        end
    endtask

    initial begin
        clear_inputs();
        clear_patterns();
        #1;
        test_reset();
        test_reset_abort();
        test_debounce();
        test_auto_repeat();
        test_brake();
        test_arbitration();
        test_fault();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cc_command_gen.md
Name: cc_command_gen

Overview:
- Driver-side front end for the cruise controller `ccc`. It takes raw driver buttons and pedals and produces the clean command inputs that `ccc` consumes: `set`, `resume`, `cancel`, `accel`, `coast`, `brake` and `throttle`.
- Functions: synchronise, debounce, edge-detect into single-cycle pulses, arbitrate priority, auto-repeat held accel/coast.
- Sits between the driver I/O pins and `ccc`. The `ccc` output `cruisecontrol` is fed back to gate auto-repeat.

Parameters:
- DEBOUNCE_CYCLES, 4: number of consecutive cycles a synchronised button level must hold before the debounced state changes.
- REPEAT_DELAY, 8: cycles from the first accel/coast pulse to the first auto-repeat pulse.
- REPEAT_PERIOD, 4: cycles between subsequent auto-repeat pulses.
- CNT_W, 8: width of the debounce and repeat counters; every count parameter must be less than 2^CNT_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- btn_set, btn_resume, btn_cancel, btn_accel, btn_coast  in  1 each  raw stalk buttons, asynchronous, bouncing.
- pedal_brake, pedal_throttle  in  1 each  raw pedal switches, asynchronous.
- cruisecontrol  in  1  engaged status from `ccc`.
- set, resume, cancel, accel, coast  out  1 each  single-cycle command pulses to `ccc`.
- brake, throttle  out  1 each  level outputs to `ccc`.
- fault  out  1  high while accel and coast are debounced-high together.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0.
  - Synchronisers, debounced states and counters clear.
  - Reset asserted mid-pulse or mid-repeat aborts it immediately; no pulse is emitted after release until a fresh qualified press.
- Synchronisation: every raw input passes through a 2-FF synchroniser.
- Pedal path:
  - brake = synchronised pedal_brake, with no debounce. Latency is 2 edges: raw sampled high at edge k, brake=1 after edge k+1.
  - throttle = pedal_throttle after synchronisation plus debounce, as a level.
- Button debounce:
  - Per-button counter increments while the synchronised level differs from the debounced state, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced state flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- Edge detect: a debounced 0->1 transition yields a raw pulse for one cycle. Falling edges yield nothing.
- Latency: raw button first sampled high at edge k -> registered command pulse high for exactly one cycle after edge k+DEBOUNCE_CYCLES+2 (after edge k+6 at defaults).
- Arbitration (registered, same cycle):
  - Priority: cancel > set > resume > accel > coast.
  - Only the highest-priority raw pulse in a cycle is output; the others are dropped, not queued.
- Brake gating: while brake=1, set, resume, accel and coast pulses are suppressed and dropped. cancel still passes.
- Fault:
  - fault=1 while debounced accel and debounced coast are both 1.
  - While fault=1, no accel/coast pulses are emitted and repeat counters hold cleared.
  - fault drops the cycle after either debounced state falls.
  - Re-arming requires a new rising edge.
- Auto-repeat (per accel/coast), states IDLE -> DELAY -> REPEAT:
  - IDLE: a first pulse is emitted -> DELAY, counter=0.
  - DELAY: counts to REPEAT_DELAY, then emits a pulse -> REPEAT.
  - REPEAT: emits a pulse every REPEAT_PERIOD cycles.
  - Any state -> IDLE when the debounced level falls, cruisecontrol=0, brake=1, or fault=1.
  - Repeat pulses obey the same arbitration as first pulses.
- Counters saturate; they never wrap.

Optional Feature:
- Macro CC_AUTOREPEAT_EN.
- Defined: auto-repeat FSM present, behaving exactly as above.
- Undefined: no repeat logic; a held accel/coast yields exactly one pulse per debounced rising edge. REPEAT_DELAY and REPEAT_PERIOD are accepted but unused.

Test Plan:
- Reset and idle: reset=0 for 3 cycles with all raw inputs toggling -> all outputs 0. Release and hold inputs low for 20 cycles -> outputs stay 0.
- Debounce:
  - btn_set high for 10 cycles -> exactly one set pulse, high after edge k+6.
  - btn_resume high for 3 cycles -> no resume pulse.
  - btn_set toggling every cycle for 20 cycles -> no pulse.
- Auto-repeat: cruisecontrol=1, btn_accel held so the debounced level is high for 30 cycles -> accel pulses at relative cycles 0, 8, 12, 16, 20, 24, 28 (7 pulses). Same stimulus with cruisecontrol=0 -> 1 pulse. Same stimulus with CC_AUTOREPEAT_EN undefined -> 1 pulse.
- Brake gating:
  - pedal_brake=1, then btn_set press -> brake=1 two edges after the pedal is sampled high, and no set pulse.
  - btn_cancel pressed during brake -> one cancel pulse.
- Arbitration: btn_cancel and btn_set rising on the same edge, both held 10 cycles -> one cancel pulse, zero set pulses.
- Fault: btn_accel and btn_coast both held for 20 cycles -> fault=1 from the cycle both debounced states are high, and no accel/coast pulses. Release btn_coast -> fault=0 and still no accel pulse until btn_accel is re-pressed.
